dut_vector_loader: RTL and testbench

- Host-side front end of the DUT control path; directly upstream of the DUT register-bank wrapper.
- Accepts a stream of 32-bit command/data words over a valid/ready handshake.
- Assembles 126-bit vectors and drives the shared 126-bit bus.
- Issues one-cycle LOAD/TRANSFER strobes to the signal, FF, FF-signal, template and cycle banks; holds the timing-edge registers and the PERFORM_TEST level.

---
 rtl/dut_ctrl_pkg.sv | 39 +++
 rtl/dut_strobe_decode.sv | 29 ++
 rtl/dut_vector_loader.sv | 224 ++++++++++++++++++++++
 tb/tb_dut_vector_loader.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dut_ctrl_pkg.sv
// Shared definitions for the DUT control path: host opcodes, bank target
// indices, loader FSM states and TIMING data-word field positions.
package dut_ctrl_pkg;

  // Header word: opcode in [31:28], target in [2:0], transfer mask in [4:0]
  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 28;

  localparam logic [3:0] OP_LOAD   = 4'd1;
  localparam logic [3:0] OP_XFER   = 4'd2;
  localparam logic [3:0] OP_TIMING = 4'd3;
  localparam logic [3:0] OP_TEST   = 4'd4;

  localparam logic [2:0] TGT_SIG      = 3'd0;
  localparam logic [2:0] TGT_FF_FF    = 3'd1;
  localparam logic [2:0] TGT_FF_SIG   = 3'd2;
  localparam logic [2:0] TGT_TEMPLATE = 3'd3;
  localparam logic [2:0] TGT_CYCLE    = 3'd4;
  localparam int unsigned NUM_TGT     = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_TIMING_DATA,
    ST_LOAD_PULSE,
    ST_XFER_PULSE
  } state_t;

  // TIMING data-word layout
  localparam int unsigned LE1_LSB = 0;
  localparam int unsigned LE1_W   = 7;
  localparam int unsigned TE1_LSB = 7;
  localparam int unsigned TE1_W   = 7;
  localparam int unsigned CL1_LSB = 14;
  localparam int unsigned CL1_W   = 8;
  localparam int unsigned LE2_LSB = 22;
  localparam int unsigned LE2_W   = 7;

endpackage

// File: rtl/dut_strobe_decode.sv
// Combinational decode of the latched target / transfer mask into the
// per-bank LOAD and TRANSFER strobes, gated by the loader pulse states.
// Ports:
//   i_load_pulse  FSM is in the LOAD pulse state
//   i_xfer_pulse  FSM is in the TRANSFER pulse state
//   i_target      latched bank index (values >= NUM_TGT select nothing)
//   i_mask        latched transfer mask, bit i = bank i
//   o_load        one-hot LOAD strobes, bit i = bank i
//   o_xfer        TRANSFER strobes, bit i = bank i
module dut_strobe_decode
  import dut_ctrl_pkg::*;
(
  input  logic               i_load_pulse,
  input  logic               i_xfer_pulse,
  input  logic [2:0]         i_target,
  input  logic [NUM_TGT-1:0] i_mask,
  output logic [NUM_TGT-1:0] o_load,
  output logic [NUM_TGT-1:0] o_xfer
);

  always_comb begin
    o_load = '0;
    for (int unsigned t = 0; t < NUM_TGT; t++) begin
      o_load[t] = i_load_pulse && (32'(i_target) == t);
    end
    o_xfer = i_xfer_pulse ? i_mask : '0;
  end

endmodule

// File: rtl/dut_vector_loader.sv
// Host-side loader: accepts 32-bit command/data words over valid/ready,
// assembles the shared vector bus, and issues one-cycle LOAD/TRANSFER
// strobes to the signal, FF, FF-signal, template and cycle banks. Also
// holds the timing-edge registers and the PERFORM_TEST level.
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   IN_DATA/IN_VALID  host word and valid; IN_READY = loader accepts
//   ERR_CLR           clears the sticky ERR flag (a same-cycle error wins)
//   BUS126            assembled vector to the register banks
//   *_LOAD            one-cycle load strobes, one per bank
//   *_TRANSFER        one-cycle transfer strobes, one per bank
//   LEADING_EDGE_1, TRAILING_EDGE_1, CYCLE_LENGTH_1, LEADING_EDGE_2
//                     timing registers
//   PERFORM_TEST      test-enable level
//   BUSY              FSM not in IDLE
//   ERR               sticky error flag
//   LOAD_COUNT        completed loads, wrapping
module dut_vector_loader
  import dut_ctrl_pkg::*;
#(
  parameter int unsigned DW     = 32,
  parameter int unsigned BUS_W  = 126,
  parameter int unsigned NWORDS = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [DW-1:0]    IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             ERR_CLR,
  output logic [BUS_W-1:0] BUS126,
  output logic             SIG_LOAD,
  output logic             FF_LOAD_FF,
  output logic             FF_LOAD_SIG,
  output logic             TEMPLATE_LOAD,
  output logic             CYCLE_LOAD,
  output logic             SIG_TRANSFER,
  output logic             FF_TRANSFER_FF,
  output logic             FF_TRANSFER_SIG,
  output logic             TEMPLATE_TRANSFER,
  output logic             CYCLE_TRANSFER,
  output logic [6:0]       LEADING_EDGE_1,
  output logic [6:0]       TRAILING_EDGE_1,
  output logic [7:0]       CYCLE_LENGTH_1,
  output logic [6:0]       LEADING_EDGE_2,
  output logic             PERFORM_TEST,
  output logic             BUSY,
  output logic             ERR,
  output logic [CNT_W-1:0] LOAD_COUNT
);

  localparam int unsigned WCW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(NWORDS - 1);

  state_t             r_state;
  logic [WCW-1:0]     r_wcnt;
  logic [2:0]         r_target;
  logic [NUM_TGT-1:0] r_mask;
  logic [BUS_W-1:0]   r_bus;
  logic [6:0]         r_le1;
  logic [6:0]         r_te1;
  logic [7:0]         r_cl1;
  logic [6:0]         r_le2;
  logic               r_pt;
  logic               r_ready;
  logic               r_err;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_accept;
  logic [3:0]         w_op;
  logic               w_tgt_ok;
  logic               w_err_set;
  logic               w_load_pulse;
  logic               w_xfer_pulse;
  logic [NUM_TGT-1:0] w_load;
  logic [NUM_TGT-1:0] w_xfer;

  assign w_accept     = IN_VALID & r_ready;
  assign w_op         = IN_DATA[OP_MSB:OP_LSB];
  assign w_tgt_ok     = (32'(r_target) < NUM_TGT);
  assign w_load_pulse = (r_state == ST_LOAD_PULSE);
  assign w_xfer_pulse = (r_state == ST_XFER_PULSE);

  always_comb begin
    w_err_set = 1'b0;
    case (r_state)
      ST_IDLE:
        w_err_set = w_accept && !(w_op inside {OP_LOAD, OP_XFER, OP_TIMING, OP_TEST});
      ST_TIMING_DATA:
        w_err_set = w_accept && r_pt;
      ST_LOAD_PULSE:
        w_err_set = !w_tgt_ok;
      default:
        w_err_set = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_wcnt   <= '0;
      r_target <= '0;
      r_mask   <= '0;
      r_bus    <= '0;
      r_le1    <= '0;
      r_te1    <= '0;
      r_cl1    <= '0;
      r_le2    <= '0;
      r_pt     <= 1'b0;
      r_ready  <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (ERR_CLR) begin
        r_err <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_target <= IN_DATA[2:0];
            r_mask   <= IN_DATA[NUM_TGT-1:0];
            case (w_op)
              OP_LOAD: begin
                r_state <= ST_COLLECT;
                r_wcnt  <= '0;
              end
              OP_XFER: begin
                r_state <= ST_XFER_PULSE;
                r_ready <= 1'b0;
              end
              OP_TIMING: r_state <= ST_TIMING_DATA;
              OP_TEST:   r_pt    <= IN_DATA[0];
              default:   r_state <= ST_IDLE;
            endcase
          end
        end

        ST_COLLECT: begin
          if (w_accept) begin
            // Write only the bus bits belonging to word slot r_wcnt; bits of
            // the last word beyond BUS_W simply have no destination.
            for (int unsigned b = 0; b < BUS_W; b++) begin
              if ((b / DW) == 32'(r_wcnt)) begin
                r_bus[b] <= IN_DATA[b % DW];
              end
            end
            r_wcnt <= r_wcnt + 1'b1;
            if (r_wcnt == LAST_WORD) begin
              r_state <= ST_LOAD_PULSE;
              r_ready <= 1'b0;
            end
          end
        end

        ST_TIMING_DATA: begin
          if (w_accept) begin
            if (!r_pt) begin
              r_le1 <= IN_DATA[LE1_LSB +: LE1_W];
              r_te1 <= IN_DATA[TE1_LSB +: TE1_W];
              r_cl1 <= IN_DATA[CL1_LSB +: CL1_W];
              r_le2 <= IN_DATA[LE2_LSB +: LE2_W];
            end
            r_state <= ST_IDLE;
          end
        end

        ST_LOAD_PULSE: begin
          if (w_tgt_ok) begin
            r_cnt <= r_cnt + 1'b1;
          end
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end

        ST_XFER_PULSE: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end

        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  dut_strobe_decode u_strobe_decode (
    .i_load_pulse (w_load_pulse),
    .i_xfer_pulse (w_xfer_pulse),
    .i_target     (r_target),
    .i_mask       (r_mask),
    .o_load       (w_load),
    .o_xfer       (w_xfer)
  );

  assign SIG_LOAD          = w_load[TGT_SIG];
  assign FF_LOAD_FF        = w_load[TGT_FF_FF];
  assign FF_LOAD_SIG       = w_load[TGT_FF_SIG];
  assign TEMPLATE_LOAD     = w_load[TGT_TEMPLATE];
  assign CYCLE_LOAD        = w_load[TGT_CYCLE];
  assign SIG_TRANSFER      = w_xfer[TGT_SIG];
  assign FF_TRANSFER_FF    = w_xfer[TGT_FF_FF];
  assign FF_TRANSFER_SIG   = w_xfer[TGT_FF_SIG];
  assign TEMPLATE_TRANSFER = w_xfer[TGT_TEMPLATE];
  assign CYCLE_TRANSFER    = w_xfer[TGT_CYCLE];

  assign IN_READY        = r_ready;
  assign BUS126          = r_bus;
  assign LEADING_EDGE_1  = r_le1;
  assign TRAILING_EDGE_1 = r_te1;
  assign CYCLE_LENGTH_1  = r_cl1;
  assign LEADING_EDGE_2  = r_le2;
  assign PERFORM_TEST    = r_pt;
  assign BUSY            = (r_state != ST_IDLE);
  assign ERR             = r_err;
  assign LOAD_COUNT      = r_cnt;

endmodule

// File: tb/tb_dut_vector_loader.sv
// Bench for dut_vector_loader: a table of directed commands, hand-written
// reset / error / stall / wrap sequences, and randomized commands checked
// against a command-level reference model. A second instance with a 4-bit
// load counter shares all inputs to exercise counter wrap cheaply.
module tb_dut_vector_loader;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [31:0]  IN_DATA = '0;
  logic         IN_VALID = 1'b0;
  logic         ERR_CLR = 1'b0;

  logic         IN_READY, SIG_LOAD, FF_LOAD_FF, FF_LOAD_SIG, TEMPLATE_LOAD, CYCLE_LOAD;
  logic         SIG_TRANSFER, FF_TRANSFER_FF, FF_TRANSFER_SIG, TEMPLATE_TRANSFER, CYCLE_TRANSFER;
  logic [125:0] BUS126;
  logic [6:0]   LEADING_EDGE_1, TRAILING_EDGE_1, LEADING_EDGE_2;
  logic [7:0]   CYCLE_LENGTH_1;
  logic         PERFORM_TEST, BUSY, ERR;
  logic [15:0]  LOAD_COUNT;

  logic         IN_READY_b, SIG_LOAD_b, FF_LOAD_FF_b, FF_LOAD_SIG_b, TEMPLATE_LOAD_b, CYCLE_LOAD_b;
  logic         SIG_TRANSFER_b, FF_TRANSFER_FF_b, FF_TRANSFER_SIG_b, TEMPLATE_TRANSFER_b, CYCLE_TRANSFER_b;
  logic [125:0] BUS126_b;
  logic [6:0]   LEADING_EDGE_1_b, TRAILING_EDGE_1_b, LEADING_EDGE_2_b;
  logic [7:0]   CYCLE_LENGTH_1_b;
  logic         PERFORM_TEST_b, BUSY_b, ERR_b;
  logic [3:0]   LOAD_COUNT_b;

  dut_vector_loader u_dut (
    .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .ERR_CLR(ERR_CLR), .BUS126(BUS126),
    .SIG_LOAD(SIG_LOAD), .FF_LOAD_FF(FF_LOAD_FF), .FF_LOAD_SIG(FF_LOAD_SIG),
    .TEMPLATE_LOAD(TEMPLATE_LOAD), .CYCLE_LOAD(CYCLE_LOAD),
    .SIG_TRANSFER(SIG_TRANSFER), .FF_TRANSFER_FF(FF_TRANSFER_FF), .FF_TRANSFER_SIG(FF_TRANSFER_SIG),
    .TEMPLATE_TRANSFER(TEMPLATE_TRANSFER), .CYCLE_TRANSFER(CYCLE_TRANSFER),
    .LEADING_EDGE_1(LEADING_EDGE_1), .TRAILING_EDGE_1(TRAILING_EDGE_1),
    .CYCLE_LENGTH_1(CYCLE_LENGTH_1), .LEADING_EDGE_2(LEADING_EDGE_2),
    .PERFORM_TEST(PERFORM_TEST), .BUSY(BUSY), .ERR(ERR), .LOAD_COUNT(LOAD_COUNT)
  );

  dut_vector_loader #(.CNT_W(4)) u_dut_c4 (
    .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID), .IN_READY(IN_READY_b),
    .ERR_CLR(ERR_CLR), .BUS126(BUS126_b),
    .SIG_LOAD(SIG_LOAD_b), .FF_LOAD_FF(FF_LOAD_FF_b), .FF_LOAD_SIG(FF_LOAD_SIG_b),
    .TEMPLATE_LOAD(TEMPLATE_LOAD_b), .CYCLE_LOAD(CYCLE_LOAD_b),
    .SIG_TRANSFER(SIG_TRANSFER_b), .FF_TRANSFER_FF(FF_TRANSFER_FF_b), .FF_TRANSFER_SIG(FF_TRANSFER_SIG_b),
    .TEMPLATE_TRANSFER(TEMPLATE_TRANSFER_b), .CYCLE_TRANSFER(CYCLE_TRANSFER_b),
    .LEADING_EDGE_1(LEADING_EDGE_1_b), .TRAILING_EDGE_1(TRAILING_EDGE_1_b),
    .CYCLE_LENGTH_1(CYCLE_LENGTH_1_b), .LEADING_EDGE_2(LEADING_EDGE_2_b),
    .PERFORM_TEST(PERFORM_TEST_b), .BUSY(BUSY_b), .ERR(ERR_b), .LOAD_COUNT(LOAD_COUNT_b)
  );

  always #5 CLK = ~CLK;

  // Bit i of each strobe group = bank i (SIG, FF_FF, FF_SIG, TEMPLATE, CYCLE)
  logic [4:0]   ld_a, xf_a, ld_b, xf_b;
  logic [158:0] obs_a, obs_b;
  assign ld_a = {CYCLE_LOAD, TEMPLATE_LOAD, FF_LOAD_SIG, FF_LOAD_FF, SIG_LOAD};
  assign xf_a = {CYCLE_TRANSFER, TEMPLATE_TRANSFER, FF_TRANSFER_SIG, FF_TRANSFER_FF, SIG_TRANSFER};
  assign ld_b = {CYCLE_LOAD_b, TEMPLATE_LOAD_b, FF_LOAD_SIG_b, FF_LOAD_FF_b, SIG_LOAD_b};
  assign xf_b = {CYCLE_TRANSFER_b, TEMPLATE_TRANSFER_b, FF_TRANSFER_SIG_b, FF_TRANSFER_FF_b, SIG_TRANSFER_b};
  assign obs_a = {BUS126, LEADING_EDGE_2, CYCLE_LENGTH_1, TRAILING_EDGE_1, LEADING_EDGE_1,
                  PERFORM_TEST, BUSY, ERR, IN_READY};
  assign obs_b = {BUS126_b, LEADING_EDGE_2_b, CYCLE_LENGTH_1_b, TRAILING_EDGE_1_b, LEADING_EDGE_1_b,
                  PERFORM_TEST_b, BUSY_b, ERR_b, IN_READY_b};

  int checks = 0;
  int failures = 0;

  // Reference model state (command level)
  logic [125:0] m_bus;
  logic [28:0]  m_tim;   // {LE2, CL1, TE1, LE1}
  logic         m_pt, m_err;
  logic [15:0]  m_cnt;
  logic [4:0]   m_ld, m_xf;

  logic [9:0]   cap_a, cap_b;
  logic [1:0]   cap_rb;
  logic [19:0]  cap_post;

  localparam logic [125:0] B0 = {30'h3FFF_FFFF, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
  localparam logic [125:0] B1 = {30'h1DDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
  localparam logic [125:0] B2 = {30'h09AB_CDEF, 32'h0123_4567, 32'hDEAD_BEEF, 32'hCAFE_F00D};

  typedef struct {
    logic [31:0]       hdr;
    logic [3:0][31:0]  d;
    logic              clr;
    logic [4:0]        ld;
    logic [4:0]        xf;
    logic              err;
    logic              pt;
    logic [15:0]       cnt;
    logic [28:0]       tim;
    logic [125:0]      bus;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [158:0] m_obs();
    return {m_bus, m_tim, m_pt, 1'b0, m_err, 1'b1};
  endfunction

  task automatic model_reset();
    m_bus = '0; m_tim = '0; m_pt = 1'b0; m_err = 1'b0; m_cnt = '0;
  endtask

  task automatic model_cmd(input logic [31:0] hdr, input logic [3:0][31:0] d);
    m_ld = '0;
    m_xf = '0;
    case (hdr[31:28])
      4'd1: begin
        m_bus = {d[3][29:0], d[2], d[1], d[0]};
        if (hdr[2:0] < 3'd5) begin
          m_ld  = 5'd1 << hdr[2:0];
          m_cnt = m_cnt + 16'd1;
        end else begin
          m_err = 1'b1;
        end
      end
      4'd2: m_xf = hdr[4:0];
      4'd3: begin
        if (m_pt) m_err = 1'b1;
        else      m_tim = d[0][28:0];
      end
      4'd4: m_pt = hdr[0];
      default: m_err = 1'b1;
    endcase
  endtask

  task automatic send_word(input logic [31:0] w, input bit stall);
    int n = 0;
    @(negedge CLK);
    if (stall) begin
      int s = int'($urandom_range(0, 3));
      for (int i = 0; i < s; i++) begin
        IN_DATA = $urandom;
        @(negedge CLK);
      end
    end
    IN_DATA  = w;
    IN_VALID = 1'b1;
    while (!IN_READY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("accept_ready", 256'(IN_READY), 256'(1));
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    IN_DATA  = $urandom;
  endtask

  // Sends a command; captures strobes in the first cycle after the final
  // accept edge, then again one cycle later.
  task automatic do_cmd(input logic [31:0] hdr, input logic [3:0][31:0] d, input bit stall);
    int nw;
    nw = (hdr[31:28] == 4'd1) ? 4 : (hdr[31:28] == 4'd3) ? 1 : 0;
    send_word(hdr, stall);
    for (int i = 0; i < nw; i++) send_word(d[i], stall);
    cap_a  = {ld_a, xf_a};
    cap_b  = {ld_b, xf_b};
    cap_rb = {IN_READY, BUSY};
    @(posedge CLK);
    #1;
    cap_post = {ld_a, xf_a, ld_b, xf_b};
  endtask

  function automatic logic [1:0] exp_rb(input logic [31:0] hdr);
    return (hdr[31:28] == 4'd1 || hdr[31:28] == 4'd2) ? 2'b01 : 2'b10;
  endfunction

  task automatic run_cmd(input logic [31:0] hdr, input logic [3:0][31:0] d, input bit stall);
    do_cmd(hdr, d, stall);
    model_cmd(hdr, d);
    chk("strobe_pulse", 256'(cap_a), 256'({m_ld, m_xf}));
    chk("strobe_pulse_b", 256'(cap_b), 256'({m_ld, m_xf}));
    chk("pulse_ready_busy", 256'(cap_rb), 256'(exp_rb(hdr)));
    chk("strobe_drop", 256'(cap_post), 256'(0));
    chk("state", 256'(obs_a), 256'(m_obs()));
    chk("state_b", 256'(obs_b), 256'(m_obs()));
    chk("count", 256'(LOAD_COUNT), 256'(m_cnt));
    chk("count_b", 256'(LOAD_COUNT_b), 256'(m_cnt[3:0]));
  endtask

  task automatic pulse_clr();
    @(negedge CLK);
    ERR_CLR = 1'b1;
    @(negedge CLK);
    ERR_CLR = 1'b0;
    m_err = 1'b0;
    chk("err_clear", 256'({ERR, ERR_b}), 256'(0));
  endtask

  // Asserts reset right now (asynchronously), checks the reset state,
  // releases on the next falling edge and checks IN_READY rises.
  task automatic do_reset();
    RST = 1'b1;
    #1;
    chk("rst_outputs", 256'(obs_a), 256'(0));
    chk("rst_outputs_b", 256'(obs_b), 256'(0));
    chk("rst_strobes", 256'({ld_a, xf_a, ld_b, xf_b}), 256'(0));
    chk("rst_count", 256'({LOAD_COUNT, LOAD_COUNT_b}), 256'(0));
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    @(posedge CLK);
    #1;
    chk("post_rst_idle", 256'(obs_a), 256'(m_obs()));
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      checks++;
      if ($countones(ld_a) > 1 || (ld_a != 5'd0 && xf_a != 5'd0)) begin
        failures++;
        $display("FAIL strobe_overlap actual=%b_%b required=at most one strobe group", ld_a, xf_a);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]      hdr;
    logic [3:0][31:0] d;

    tbl[0]  = '{32'h1000_0000, {32'hFFFF_FFFF, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111},
                1'b0, 5'b00001, 5'b00000, 1'b0, 1'b0, 16'd1, 29'h0, B0};
    tbl[1]  = '{32'h2000_0015, 128'h0, 1'b0, 5'b00000, 5'b10101, 1'b0, 1'b0, 16'd1, 29'h0, B0};
    tbl[2]  = '{32'h3000_0000, {96'h0, 32'h0159_140A},
                1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 16'd1, 29'h0159_140A, B0};
    tbl[3]  = '{32'h4000_0001, 128'h0, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b1, 16'd1, 29'h0159_140A, B0};
    tbl[4]  = '{32'h3000_0000, {96'h0, 32'h1FFF_FFFF},
                1'b0, 5'b00000, 5'b00000, 1'b1, 1'b1, 16'd1, 29'h0159_140A, B0};
    tbl[5]  = '{32'h4000_0000, 128'h0, 1'b1, 5'b00000, 5'b00000, 1'b0, 1'b0, 16'd1, 29'h0159_140A, B0};
    tbl[6]  = '{32'h1000_0006, {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA},
                1'b0, 5'b00000, 5'b00000, 1'b1, 1'b0, 16'd1, 29'h0159_140A, B1};
    tbl[7]  = '{32'h4000_0000, 128'h0, 1'b1, 5'b00000, 5'b00000, 1'b0, 1'b0, 16'd1, 29'h0159_140A, B1};
    tbl[8]  = '{32'hF000_0000, 128'h0, 1'b0, 5'b00000, 5'b00000, 1'b1, 1'b0, 16'd1, 29'h0159_140A, B1};
    tbl[9]  = '{32'h2000_0000, 128'h0, 1'b1, 5'b00000, 5'b00000, 1'b0, 1'b0, 16'd1, 29'h0159_140A, B1};
    tbl[10] = '{32'h1000_0004, {32'h89AB_CDEF, 32'h0123_4567, 32'hDEAD_BEEF, 32'hCAFE_F00D},
                1'b0, 5'b10000, 5'b00000, 1'b0, 1'b0, 16'd2, 29'h0159_140A, B2};

    model_reset();
    do_reset();

    // Directed table
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].clr) pulse_clr();
      do_cmd(tbl[i].hdr, tbl[i].d, 1'b0);
      model_cmd(tbl[i].hdr, tbl[i].d);
      chk("tbl_strobe", 256'(cap_a), 256'({tbl[i].ld, tbl[i].xf}));
      chk("tbl_strobe_b", 256'(cap_b), 256'({tbl[i].ld, tbl[i].xf}));
      chk("tbl_pulse_ready_busy", 256'(cap_rb), 256'(exp_rb(tbl[i].hdr)));
      chk("tbl_strobe_drop", 256'(cap_post), 256'(0));
      chk("tbl_state", 256'(obs_a),
          256'({tbl[i].bus, tbl[i].tim, tbl[i].pt, 1'b0, tbl[i].err, 1'b1}));
      chk("tbl_state_b", 256'(obs_b),
          256'({tbl[i].bus, tbl[i].tim, tbl[i].pt, 1'b0, tbl[i].err, 1'b1}));
      chk("tbl_count", 256'(LOAD_COUNT), 256'(tbl[i].cnt));
      chk("tbl_count_b", 256'(LOAD_COUNT_b), 256'(tbl[i].cnt[3:0]));
    end

    // ERR_CLR held across a new error: the error wins
    ERR_CLR = 1'b1;
    send_word(32'hF000_0000, 1'b0);
    chk("err_set_wins", 256'({ERR, ERR_b}), 256'(2'b11));
    ERR_CLR = 1'b0;
    m_err = 1'b1;
    pulse_clr();

    // Same vector as the first table entry, with random IN_VALID stalls
    run_cmd(tbl[0].hdr, tbl[0].d, 1'b1);
    chk("stalled_bus", 256'(BUS126), 256'(B0));

    // Reset during the LOAD pulse: strobe drops without waiting for a clock
    send_word(32'h1000_0001, 1'b0);
    for (int i = 0; i < 4; i++) send_word(32'h5555_0000 + 32'(i), 1'b0);
    chk("pulse_before_rst", 256'(ld_a), 256'(5'b00010));
    do_reset();

    // Reset after two data words, with a long IN_VALID stall in COLLECT
    send_word(32'h1000_0000, 1'b0);
    send_word(32'hA5A5_0001, 1'b0);
    repeat (30) @(negedge CLK);
    chk("stall_hold", 256'({BUSY, IN_READY, BUS126[31:0]}), 256'({2'b11, 32'hA5A5_0001}));
    send_word(32'hA5A5_0002, 1'b0);
    chk("partial_bus", 256'(BUS126[63:0]), 256'(64'hA5A5_0002_A5A5_0001));
    do_reset();
    d = {32'h7654_3210, 32'h0F0F_0F0F, 32'h1234_5678, 32'h9ABC_DEF0};
    run_cmd(32'h1000_0002, d, 1'b0);

    // Counter wrap on the 4-bit instance
    do_reset();
    for (int i = 0; i < 16; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      run_cmd(32'h1000_0003, d, 1'b0);
    end
    chk("wrap_count_b", 256'(LOAD_COUNT_b), 256'(0));
    chk("count_16", 256'(LOAD_COUNT), 256'(16));

    // Randomized commands against the model
    for (int n = 0; n < 150; n++) begin
      int r, o;
      r = int'($urandom_range(0, 9));
      hdr = $urandom;
      d = {$urandom, $urandom, $urandom, $urandom};
      if (r <= 3)      hdr[31:28] = 4'd1;
      else if (r <= 5) hdr[31:28] = 4'd2;
      else if (r == 6) hdr[31:28] = 4'd3;
      else if (r == 7) begin
        hdr[31:28] = 4'd4;
        hdr[0] = ($urandom_range(0, 3) == 0);
      end else begin
        o = int'($urandom_range(5, 16));
        hdr[31:28] = (o == 16) ? 4'd0 : 4'(o);
      end
      if (r == 9) pulse_clr();
      else        run_cmd(hdr, d, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
